tron_arena_arbiter: RTL and testbench
=====================================

Name: tron_arena_arbiter

Overview:
- Sits between the two tron datapaths (head coordinates) and the single vga_adapter (x/y/colour/plot).
- Holds a 160x120 occupancy bitmap and serialises both players' head updates into one plot stream.
- Detects collisions with walls, trails, the out-of-arena region and each other; reports per-player death.
- Clears and redraws the arena on reset or on request for a new round.

Parameters:
- BX0, 10, left wall x
- BX1, 149, right wall x
- BY0, 17, top wall y
- BY1, 108, bottom wall y
- P1_COLOUR, 3'b001, player 1 trail colour
- P2_COLOUR, 3'b100, player 2 trail colour
- WALL_COLOUR, 3'b111, wall colour
- BG_COLOUR, 3'b000, background colour

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- step  in  1  one-cycle pulse: new head positions valid
- p1_x  in  8  player 1 head x
- p1_y  in  7  player 1 head y
- p2_x  in  8  player 2 head x
- p2_y  in  7  player 2 head y
- clear_req  in  1  start arena clear / new round
- x  out  8  VGA plot x
- y  out  7  VGA plot y
- colour  out  3  VGA plot colour
- plot  out  1  VGA write strobe, one cycle per pixel
- busy  out  1  high whenever state is not IDLE
- dead_p1  out  1  sticky, player 1 has crashed
- dead_p2  out  1  sticky, player 2 has crashed
- round_over  out  1  dead_p1 | dead_p2

Behaviour:
- Reset: x=0, y=0, colour=0, plot=0, dead_p1=0, dead_p2=0, last-head registers=8'hFF/7'h7F, state=CLEAR, scan counter=0. busy=1 from the first edge after reset falls.
- Bitmap: 19200 x 1 bit, single port, synchronous read with 1-cycle latency. Address = y*160 + x.
- States: CLEAR, IDLE, P1_RD, P1_WR, P2_RD, P2_WR.
- CLEAR:
  - One cell per cycle, x fastest (0..159), y outer (0..119); plot=1 every cycle, 19200 plots total.
  - Wall cell (x in {BX0,BX1} with BY0<=y<=BY1, or y in {BY0,BY1} with BX0<=x<=BX1): WALL_COLOUR, bit=1.
  - Outside the wall rectangle: BG_COLOUR, bit=1.
  - Inside: BG_COLOUR, bit=0.
  - After cell (159,119): clear dead flags and last-heads, go to IDLE.
- IDLE:
  - clear_req goes to CLEAR; it has priority over step in the same cycle.
  - step with round_over=0 latches both positions, goes to P1_RD.
  - step with round_over=1 is ignored.
  - clear_req and step in any other state are ignored (no queueing).
- P1_RD: issue read of p1 cell.
- P1_WR: evaluate p1:
  - Same as last head: no plot, no death.
  - x>=160, y>=120, bit=1, or p1==p2: dead_p1=1, no plot.
  - Otherwise write bit=1, plot p1 at P1_COLOUR, update last head.
- P2_RD / P2_WR: same rules for player 2. The p2 read observes p1's write from this step. p1==p2 (both not stationary) also sets dead_p2.
- Timing: step sampled at edge N. p1 plot is visible in the cycle after edge N+2; p2 plot in the cycle after edge N+4; IDLE (busy=0) after edge N+5. A step is therefore accepted at most every 5 cycles.
- Plot gaps: plot=0 in P1_RD, P2_RD, IDLE, and in any WR state with no plot.
- Death: flags are sticky until the CLEAR completes. Both players are still evaluated within the step in which the first death occurs.
- Reset mid-operation: abort immediately, restart CLEAR at cell 0.

Test Plan:
- Reset release -> 19200 plot pulses over exactly 19200 cycles; 460 at WALL_COLOUR; busy falls after the last one; deaths 0.
- step p1=(25,100), p2=(100,100) -> (25,100,001) plotted, then (100,100,100) 2 cycles later; busy high 5 cycles; no deaths.
- Repeat step with the same positions -> no plot pulses, no deaths.
- step p1=(10,50) wall, p2=(101,100) -> dead_p1=1, round_over=1, only (101,100,100) plotted; a following step produces no activity.
- Both heads at (60,60) -> dead_p1=dead_p2=1, zero plots. Separately, p1 x=200 -> dead_p1.
- p2 path (100,100)->(101,100)->(100,100) -> dead_p2 on the third step. Then clear_req and step together -> CLEAR wins, 19200 plots, flags cleared.

Source files
------------

// File: rtl/tron_arena_arbiter.sv
// rtl/tron_arena_arbiter.sv - arena occupancy bitmap, collision detection and plot serialiser for two tron players
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-high reset; restarts the arena clear
//   step                 one-cycle pulse, p1/p2 head positions are valid
//   p1_x, p1_y           player 1 head position
//   p2_x, p2_y           player 2 head position
//   clear_req            request an arena clear / new round
//   x, y, colour, plot   registered pixel write stream to the VGA adapter
//   busy                 registered, high while a clear or step is in progress
//   dead_p1, dead_p2     sticky crash flags, cleared when a clear completes
//   round_over           dead_p1 | dead_p2

module tron_arena_arbiter #(
    parameter logic [7:0] BX0         = 8'd10,
    parameter logic [7:0] BX1         = 8'd149,
    parameter logic [6:0] BY0         = 7'd17,
    parameter logic [6:0] BY1         = 7'd108,
    parameter logic [2:0] P1_COLOUR   = 3'b001,
    parameter logic [2:0] P2_COLOUR   = 3'b100,
    parameter logic [2:0] WALL_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [6:0] p2_y,
    input  logic       clear_req,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       dead_p1,
    output logic       dead_p2,
    output logic       round_over
);

    typedef enum logic [2:0] {CLEAR, IDLE, P1_RD, P1_WR, P2_RD, P2_WR} state_t;

    state_t      state;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic [7:0]  h1x, h2x, l1x, l2x;
    logic [6:0]  h1y, h2y, l1y, l2y;

    logic        mem [0:19199];
    logic        rd_bit;

    logic        is_p1;
    logic [7:0]  hx, lx;
    logic [6:0]  hy, ly;
    logic [14:0] mem_addr;
    logic        mem_we, mem_wd;
    logic        stationary, heads_meet, crash, head_wr;
    logic        in_rect, on_wall;

    // y*160 + x built from shifts so no multiplier is needed
    function automatic logic [14:0] cell_addr(input logic [7:0] fx, input logic [6:0] fy);
        return {1'b0, fy, 7'b0} + {3'b0, fy, 5'b0} + {7'b0, fx};
    endfunction

    always_comb begin
        is_p1      = (state == P1_RD) || (state == P1_WR);
        hx         = is_p1 ? h1x : h2x;
        hy         = is_p1 ? h1y : h2y;
        lx         = is_p1 ? l1x : l2x;
        ly         = is_p1 ? l1y : l2y;
        mem_addr   = (state == CLEAR) ? cell_addr(cx, cy) : cell_addr(hx, hy);
        stationary = (hx == lx) && (hy == ly);
        heads_meet = (h1x == h2x) && (h1y == h2y);
        // rd_bit holds the cell read in the preceding RD state
        crash      = (hx >= 8'd160) || (hy >= 7'd120) || rd_bit || heads_meet;
        head_wr    = ((state == P1_WR) || (state == P2_WR)) && !stationary && !crash;
        in_rect    = (cx >= BX0) && (cx <= BX1) && (cy >= BY0) && (cy <= BY1);
        on_wall    = in_rect && ((cx == BX0) || (cx == BX1) || (cy == BY0) || (cy == BY1));
        mem_we     = (state == CLEAR) || head_wr;
        // cells outside the playfield are marked occupied so heads there crash
        mem_wd     = (state == CLEAR) ? (!in_rect || on_wall) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mem_addr < 15'd19200) begin
            if (mem_we) mem[mem_addr] <= mem_wd;
            rd_bit <= mem[mem_addr];
        end else begin
            rd_bit <= 1'b1;
        end
    end

    assign round_over = dead_p1 | dead_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            cx      <= '0;
            cy      <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            dead_p1 <= 1'b0;
            dead_p2 <= 1'b0;
            h1x     <= '0;
            h1y     <= '0;
            h2x     <= '0;
            h2y     <= '0;
            l1x     <= 8'hFF;
            l1y     <= 7'h7F;
            l2x     <= 8'hFF;
            l2y     <= 7'h7F;
        end else begin
            plot <= 1'b0;
            busy <= 1'b1;
            case (state)
                CLEAR: begin
                    x      <= cx;
                    y      <= cy;
                    colour <= on_wall ? WALL_COLOUR : BG_COLOUR;
                    plot   <= 1'b1;
                    if (cx == 8'd159) begin
                        cx <= '0;
                        if (cy == 7'd119) begin
                            cy      <= '0;
                            state   <= IDLE;
                            dead_p1 <= 1'b0;
                            dead_p2 <= 1'b0;
                            l1x     <= 8'hFF;
                            l1y     <= 7'h7F;
                            l2x     <= 8'hFF;
                            l2y     <= 7'h7F;
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                    end else if (step && !round_over) begin
                        h1x   <= p1_x;
                        h1y   <= p1_y;
                        h2x   <= p2_x;
                        h2y   <= p2_y;
                        state <= P1_RD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                P1_RD: state <= P1_WR;
                P1_WR: begin
                    if (!stationary) begin
                        if (crash) begin
                            dead_p1 <= 1'b1;
                        end else begin
                            x      <= h1x;
                            y      <= h1y;
                            colour <= P1_COLOUR;
                            plot   <= 1'b1;
                            l1x    <= h1x;
                            l1y    <= h1y;
                        end
                    end
                    state <= P2_RD;
                end
                P2_RD: state <= P2_WR;
                P2_WR: begin
                    if (!stationary) begin
                        if (crash) begin
                            dead_p2 <= 1'b1;
                        end else begin
                            x      <= h2x;
                            y      <= h2y;
                            colour <= P2_COLOUR;
                            plot   <= 1'b1;
                            l2x    <= h2x;
                            l2y    <= h2y;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_tron_arena_arbiter.sv
// tb/tb_tron_arena_arbiter.sv - directed self-checking bench for tron_arena_arbiter

module tb_tron_arena_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic [7:0] p1_x = '0;
    logic [6:0] p1_y = '0;
    logic [7:0] p2_x = '0;
    logic [6:0] p2_y = '0;
    logic       clear_req = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       dead_p1;
    logic       dead_p2;
    logic       round_over;

    int total = 0;
    int bad = 0;

    tron_arena_arbiter dut (
        .clk(clk),
        .reset(reset),
        .step(step),
        .p1_x(p1_x),
        .p1_y(p1_y),
        .p2_x(p2_x),
        .p2_y(p2_y),
        .clear_req(clear_req),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .busy(busy),
        .dead_p1(dead_p1),
        .dead_p2(dead_p2),
        .round_over(round_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Follows one full arena clear, checking every plotted cell against the expected raster.
    task automatic wait_clear(input string tag);
        int idx = 0;
        int walls = 0;
        int seq_err = 0;
        int ex, ey;
        logic wall;
        for (int k = 0; k < 19400; k++) begin
            @(negedge clk);
            clear_req = 1'b0;
            step = 1'b0;
            if (plot) begin
                ex = idx % 160;
                ey = idx / 160;
                wall = ((ex == 10 || ex == 149) && ey >= 17 && ey <= 108) ||
                       ((ey == 17 || ey == 108) && ex >= 10 && ex <= 149);
                if (wall) walls++;
                if (x !== 8'(ex) || y !== 7'(ey) || colour !== (wall ? 3'b111 : 3'b000)) seq_err++;
                idx++;
            end else if (idx > 0) begin
                break;
            end
        end
        chk({tag, "_plots"}, idx, 19200);
        chk({tag, "_walls"}, walls, 460);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dead_p1"}, dead_p1, 0);
        chk({tag, "_dead_p2"}, dead_p2, 0);
        chk({tag, "_round_over"}, round_over, 0);
    endtask

    // Issues one step and watches the 8 following cycles.
    // acc: step should be accepted; e1/e2: player 1/2 pixel expected.
    task automatic do_step(input string tag, input logic [7:0] ax, input logic [6:0] ay,
                           input logic [7:0] bx, input logic [6:0] by,
                           input int acc, input int e1, input int e2);
        int np = 0;
        int nb = 0;
        logic s2, s4;
        logic [17:0] c2, c4;
        @(negedge clk);
        step = 1'b1;
        p1_x = ax;
        p1_y = ay;
        p2_x = bx;
        p2_y = by;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            step = 1'b0;
            if (k == 2) begin s2 = plot; c2 = {x, y, colour}; end
            if (k == 4) begin s4 = plot; c4 = {x, y, colour}; end
            if (k == 5) chk({tag, "_busy_s5"}, busy, 0);
            np += int'(plot);
            nb += int'(busy);
        end
        chk({tag, "_nplots"}, np, e1 + e2);
        chk({tag, "_nbusy"}, nb, acc * 5);
        chk({tag, "_p1_plot"}, s2, e1);
        chk({tag, "_p2_plot"}, s4, e2);
        if (e1 != 0) chk({tag, "_p1_pix"}, c2, {ax, ay, 3'b001});
        if (e2 != 0) chk({tag, "_p2_pix"}, c4, {bx, by, 3'b100});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dead_p1", dead_p1, 0);
        chk("rst_dead_p2", dead_p2, 0);
        chk("rst_round_over", round_over, 0);

        // start a clear, abort it with reset part-way through, then let it run
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_plot_before", plot, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_x", x, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_clear("clr0");

        do_step("s1", 8'd25, 7'd100, 8'd100, 7'd100, 1, 1, 1);
        chk("s1_dead_p1", dead_p1, 0);
        chk("s1_dead_p2", dead_p2, 0);
        do_step("s2_same", 8'd25, 7'd100, 8'd100, 7'd100, 1, 0, 0);
        chk("s2_round_over", round_over, 0);
        do_step("s3_p2mv", 8'd25, 7'd100, 8'd101, 7'd100, 1, 0, 1);
        chk("s3_round_over", round_over, 0);
        // p1 off-screen and p2 back onto its own trail: both die in one step
        do_step("s4_dbl", 8'd200, 7'd100, 8'd100, 7'd100, 1, 0, 0);
        chk("s4_dead_p1", dead_p1, 1);
        chk("s4_dead_p2", dead_p2, 1);
        chk("s4_round_over", round_over, 1);

        // clear_req and step together: clear wins
        @(negedge clk);
        clear_req = 1'b1;
        step = 1'b1;
        p1_x = 8'd50;
        p1_y = 7'd50;
        p2_x = 8'd70;
        p2_y = 7'd70;
        wait_clear("clr1");

        do_step("s5_wall", 8'd10, 7'd50, 8'd101, 7'd100, 1, 0, 1);
        chk("s5_dead_p1", dead_p1, 1);
        chk("s5_dead_p2", dead_p2, 0);
        chk("s5_round_over", round_over, 1);
        do_step("s6_ign", 8'd30, 7'd30, 8'd40, 7'd40, 0, 0, 0);
        chk("s6_dead_p2", dead_p2, 0);

        @(negedge clk);
        clear_req = 1'b1;
        wait_clear("clr2");

        do_step("s7_meet", 8'd60, 7'd60, 8'd60, 7'd60, 1, 0, 0);
        chk("s7_dead_p1", dead_p1, 1);
        chk("s7_dead_p2", dead_p2, 1);
        chk("s7_round_over", round_over, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
